// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC selection and interrupt/exception control for the MIPS fetch stage.
// Picks the next fetch PC from sequential, branch, jump, interrupt-vector and
// exception-vector sources, and drives the fetch PC write enable. It also
// raises the IF/ID and ID/EX flushes, latches pending interrupts and captures
// the return address (EPC). Kernel mode is PC bit 31.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   pc_plus_4        fetch PC + 4 (bit 31 = current mode)
//   id_pc_plus_4     PC + 4 of the instruction in ID
//   irq              external interrupt request (level)
//   stall            load-use stall, freezes the PC
//   branch_taken/branch_target   EX branch resolution
//   jump/jump_reg/jump_target    ID jump decode (jump_reg = jr/jalr)
//   exc              undefined instruction decoded in ID
//   pc_next/pc_write fetch PC value and write enable
//   flush_if/flush_id            pipeline register clears
//   epc/epc_write    registered return address and its $k0 write strobe
//   irq_pending      latched interrupt
//   state            0 RUN, 1 KERNEL, 2 GUARD
module pc_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h80000000,
   parameter logic [31:0] INT_VEC   = 32'h80000004,
   parameter logic [31:0] EXC_VEC   = 32'h80000008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_plus_4,
   input  logic [31:0] id_pc_plus_4,
   input  logic        irq,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic [31:0] jump_target,
   input  logic        exc,
   output logic [31:0] pc_next,
   output logic        pc_write,
   output logic        flush_if,
   output logic        flush_id,
   output logic [31:0] epc,
   output logic        epc_write,
   output logic        irq_pending,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      KERNEL = 2'd1,
      GUARD  = 2'd2
   } stateT;

   // The reset PC decides which mode we come up in.
   localparam stateT RESET_STATE = RESET_VEC[31] ? KERNEL : RUN;

   stateT stateReg, nextState;
   logic  mode;
   logic  takeIrq;
   logic  takeExc;
   logic  redirect;

   // Branch targets inherit the current mode, so bit 31 of the target is dropped.
   logic  unusedBits;
   assign unusedBits = branch_target[31];

   assign mode = pc_plus_4[31];

   // Interrupts only in RUN, and only on a quiet cycle so nothing younger is lost.
   assign takeIrq = (stateReg == RUN) & irq_pending & ~branch_taken & ~jump
                    & ~exc & ~stall;
   // An exc on the wrong path (branch taken) or in kernel code is a nop.
   assign takeExc = exc & ~branch_taken & ~mode & (stateReg != KERNEL);

   assign redirect = branch_taken | takeExc | jump | takeIrq;

   always_comb begin
      pc_next   = pc_plus_4;
      pc_write  = 1'b1;
      flush_if  = 1'b0;
      flush_id  = 1'b0;
      epc_write = 1'b0;
      if (branch_taken) begin
         pc_next  = {mode, branch_target[30:0]};
         flush_if = 1'b1;
         flush_id = 1'b1;
      end else if (takeExc) begin
         pc_next   = EXC_VEC;
         flush_if  = 1'b1;
         flush_id  = 1'b1;
         epc_write = 1'b1;
      end else if (jump) begin
         // jr/jalr may drop to user but can never climb into kernel.
         pc_next  = jump_reg ? {jump_target[31] & mode, jump_target[30:0]}
                             : {mode, jump_target[30:0]};
         flush_if = 1'b1;
      end else if (takeIrq) begin
         // The instruction in ID completes; only the fetch slot is squashed.
         pc_next   = INT_VEC;
         flush_if  = 1'b1;
         epc_write = 1'b1;
      end else if (stall) begin
         pc_write = 1'b0;
      end
   end

   always_comb begin
      nextState = stateReg;
      case (stateReg)
         RUN: begin
            if (takeIrq | takeExc) nextState = KERNEL;
         end
         KERNEL: begin
            if (pc_write & ~pc_next[31]) nextState = GUARD;
         end
         GUARD: begin
            // Hold off interrupts until one user instruction has been fetched
            // without a redirect, so a handler return always makes progress.
            if (takeExc)                   nextState = KERNEL;
            else if (pc_write & ~redirect) nextState = RUN;
         end
         default: nextState = KERNEL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stateReg <= RESET_STATE;
      else       stateReg <= nextState;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        epc <= 32'd0;
      else if (takeExc) epc <= id_pc_plus_4 - 32'd4;
      else if (takeIrq) epc <= pc_plus_4 - 32'd4;
   end

   // Set wins over clear: a level irq still asserted at take stays pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        irq_pending <= 1'b0;
      else if (irq)     irq_pending <= 1'b1;
      else if (takeIrq) irq_pending <= 1'b0;
   end

   assign state = stateReg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a cycle-by-cycle vector table (inputs plus expected
// outputs) played through a scoreboard queue, then hand-written reset checks.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_plus_4, id_pc_plus_4, branch_target, jump_target;
   logic        irq, stall, branch_taken, jump, jump_reg, exc;
   logic [31:0] pc_next, epc;
   logic        pc_write, flush_if, flush_id, epc_write, irq_pending;
   logic [1:0]  state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .reset(reset),
      .pc_plus_4(pc_plus_4), .id_pc_plus_4(id_pc_plus_4),
      .irq(irq), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_reg(jump_reg), .jump_target(jump_target),
      .exc(exc),
      .pc_next(pc_next), .pc_write(pc_write),
      .flush_if(flush_if), .flush_id(flush_id),
      .epc(epc), .epc_write(epc_write),
      .irq_pending(irq_pending), .state(state)
   );

   typedef struct {
      logic [31:0] pp4, idp, bt, jt;
      logic        irq, stl, br, jmp, jr, exc;
      logic [31:0] pcn, epcv;
      logic        pw, fi, fd, ew, ip;
      logic [1:0]  st;
   } vecT;

   localparam int NV = 28;
   vecT vecs [NV];
   vecT sb[$];

   function automatic vecT mk(
      logic [31:0] pp4, logic [31:0] idp, logic irq, logic stl, logic br,
      logic [31:0] bt, logic jmp, logic jr, logic [31:0] jt, logic exc,
      logic [31:0] pcn, logic pw, logic fi, logic fd, logic ew,
      logic [31:0] epcv, logic ip, logic [1:0] st);
      vecT v;
      v.pp4 = pp4; v.idp = idp; v.irq = irq; v.stl = stl; v.br = br;
      v.bt = bt; v.jmp = jmp; v.jr = jr; v.jt = jt; v.exc = exc;
      v.pcn = pcn; v.pw = pw; v.fi = fi; v.fd = fd; v.ew = ew;
      v.epcv = epcv; v.ip = ip; v.st = st;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      pc_plus_4 = 32'h80000004; id_pc_plus_4 = 0; irq = 0; stall = 0;
      branch_taken = 0; branch_target = 0; jump = 0; jump_reg = 0;
      jump_target = 0; exc = 0;
   endtask

   initial begin
      //           pp4         idp  irq stl br bt          jmp jr jt          exc  pcn         pw fi fd ew epc         ip st
      vecs[0]  = mk(32'h80000004, 0, 0, 0, 0, 0,           0, 0, 0,           0, 32'h80000004, 1, 0, 0, 0, 0,           0, 1);
      vecs[1]  = mk(32'h80000008, 0, 1, 0, 0, 0,           1, 1, 32'h100,     0, 32'h00000100, 1, 1, 0, 0, 0,           0, 1);
      vecs[2]  = mk(32'h00000104, 0, 0, 0, 0, 0,           0, 0, 0,           0, 32'h00000104, 1, 0, 0, 0, 0,           1, 2);
      vecs[3]  = mk(32'h00000108, 0, 0, 0, 0, 0,           0, 0, 0,           0, 32'h80000004, 1, 1, 0, 1, 0,           1, 0);
      vecs[4]  = mk(32'h80000008, 0, 0, 0, 0, 0,           0, 0, 0,           0, 32'h80000008, 1, 0, 0, 0, 32'h104,     0, 1);
      vecs[5]  = mk(32'h8000000C, 0, 0, 0, 0, 0,           1, 1, 32'h200,     0, 32'h00000200, 1, 1, 0, 0, 32'h104,     0, 1);
      vecs[6]  = mk(32'h00000204, 0, 0, 0, 0, 0,           0, 0, 0,           0, 32'h00000204, 1, 0, 0, 0, 32'h104,     0, 2);
      vecs[7]  = mk(32'h00000200, 0, 1, 0, 0, 0,           0, 0, 0,           0, 32'h00000200, 1, 0, 0, 0, 32'h104,     0, 0);
      vecs[8]  = mk(32'h00000204, 0, 0, 0, 0, 0,           0, 0, 0,           0, 32'h80000004, 1, 1, 0, 1, 32'h104,     1, 0);
      vecs[9]  = mk(32'h80000008, 0, 0, 0, 0, 0,           0, 0, 0,           0, 32'h80000008, 1, 0, 0, 0, 32'h200,     0, 1);
      vecs[10] = mk(32'h8000000C, 0, 0, 0, 0, 0,           1, 1, 32'h300,     0, 32'h00000300, 1, 1, 0, 0, 32'h200,     0, 1);
      vecs[11] = mk(32'h00000304, 32'h40, 0, 0, 0, 0,      0, 0, 0,           1, 32'h80000008, 1, 1, 1, 1, 32'h200,     0, 2);
      vecs[12] = mk(32'h8000000C, 32'h44, 0, 0, 0, 0,      0, 0, 0,           1, 32'h8000000C, 1, 0, 0, 0, 32'h3C,      0, 1);
      vecs[13] = mk(32'h80000010, 0, 0, 0, 0, 0,           1, 1, 32'h400,     0, 32'h00000400, 1, 1, 0, 0, 32'h3C,      0, 1);
      vecs[14] = mk(32'h00000404, 0, 0, 0, 0, 0,           0, 0, 0,           0, 32'h00000404, 1, 0, 0, 0, 32'h3C,      0, 2);
      vecs[15] = mk(32'h00000408, 32'h50, 0, 0, 0, 0,      0, 0, 0,           1, 32'h80000008, 1, 1, 1, 1, 32'h3C,      0, 0);
      vecs[16] = mk(32'h8000000C, 0, 0, 0, 0, 0,           1, 1, 32'h500,     0, 32'h00000500, 1, 1, 0, 0, 32'h4C,      0, 1);
      vecs[17] = mk(32'h00000504, 0, 0, 0, 0, 0,           0, 0, 0,           0, 32'h00000504, 1, 0, 0, 0, 32'h4C,      0, 2);
      vecs[18] = mk(32'h00000508, 32'h60, 0, 0, 1, 32'h700, 0, 0, 0,           1, 32'h00000700, 1, 1, 1, 0, 32'h4C,      0, 0);
      vecs[19] = mk(32'h00000704, 0, 0, 0, 0, 0,           1, 1, 32'h80001000, 0, 32'h00001000, 1, 1, 0, 0, 32'h4C,    0, 0);
      vecs[20] = mk(32'h00001004, 0, 1, 0, 0, 0,           1, 0, 32'h2000,    0, 32'h00002000, 1, 1, 0, 0, 32'h4C,      0, 0);
      vecs[21] = mk(32'h00002004, 0, 0, 0, 0, 0,           1, 0, 32'h3000,    0, 32'h00003000, 1, 1, 0, 0, 32'h4C,      1, 0);
      vecs[22] = mk(32'h00003004, 0, 0, 1, 0, 0,           0, 0, 0,           0, 32'h00003004, 0, 0, 0, 0, 32'h4C,      1, 0);
      vecs[23] = mk(32'h00003004, 0, 0, 1, 0, 0,           0, 0, 0,           0, 32'h00003004, 0, 0, 0, 0, 32'h4C,      1, 0);
      vecs[24] = mk(32'h00003004, 0, 1, 1, 0, 0,           0, 0, 0,           0, 32'h00003004, 0, 0, 0, 0, 32'h4C,      1, 0);
      vecs[25] = mk(32'h00003004, 0, 1, 0, 0, 0,           0, 0, 0,           0, 32'h80000004, 1, 1, 0, 1, 32'h4C,      1, 0);
      vecs[26] = mk(32'h80000008, 0, 0, 0, 1, 32'h10,      0, 0, 0,           0, 32'h80000010, 1, 1, 1, 0, 32'h3000,    1, 1);
      vecs[27] = mk(32'h80000014, 0, 0, 1, 0, 0,           1, 0, 32'h80,      0, 32'h80000080, 1, 1, 0, 0, 32'h3000,    1, 1);

      idle();
      reset = 1'b1;
      #2;
      chk("rst.state", 32'(state), 32'd1);
      chk("rst.epc", epc, 32'd0);
      chk("rst.irq_pending", 32'(irq_pending), 32'd0);
      chk("rst.pc_next", pc_next, 32'h80000004);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         pc_plus_4 = vecs[i].pp4; id_pc_plus_4 = vecs[i].idp; irq = vecs[i].irq;
         stall = vecs[i].stl; branch_taken = vecs[i].br; branch_target = vecs[i].bt;
         jump = vecs[i].jmp; jump_reg = vecs[i].jr; jump_target = vecs[i].jt;
         exc = vecs[i].exc;
         sb.push_back(vecs[i]);
         @(negedge clk);
         if (sb.size() == 0) begin
            chk($sformatf("v%0d.sb_empty", i), 32'd0, 32'd1);
         end else begin
            vecT e;
            e = sb.pop_front();
            chk($sformatf("v%0d.pc_next", i), pc_next, e.pcn);
            chk($sformatf("v%0d.pc_write", i), 32'(pc_write), 32'(e.pw));
            chk($sformatf("v%0d.flush_if", i), 32'(flush_if), 32'(e.fi));
            chk($sformatf("v%0d.flush_id", i), 32'(flush_id), 32'(e.fd));
            chk($sformatf("v%0d.epc_write", i), 32'(epc_write), 32'(e.ew));
            chk($sformatf("v%0d.epc", i), epc, e.epcv);
            chk($sformatf("v%0d.irq_pending", i), 32'(irq_pending), 32'(e.ip));
            chk($sformatf("v%0d.state", i), 32'(state), 32'(e.st));
         end
      end

      // Reset arriving mid-redirect with an interrupt pending.
      @(posedge clk); #1;
      idle();
      pc_plus_4 = 32'h80000084; branch_taken = 1; branch_target = 32'h00000900;
      reset = 1'b1;
      #1;
      chk("midrst.state", 32'(state), 32'd1);
      chk("midrst.irq_pending", 32'(irq_pending), 32'd0);
      chk("midrst.epc", epc, 32'd0);
      chk("midrst.pc_next", pc_next, 32'h80000900);
      chk("midrst.flush_id", 32'(flush_id), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      idle();
      pc_plus_4 = 32'h80000088;
      @(posedge clk); #1;
      chk("postrst.state", 32'(state), 32'd1);
      chk("postrst.epc", epc, 32'd0);
      chk("postrst.pc_next", pc_next, 32'h80000088);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
